// File: rtl/uart_tx_arb_if.sv
// Two-requester UART transmit bus: request side, grant/ack side and the UART write port.
// The arbiter takes the slave modport; requesters and the transmitter model sit on master.
interface uart_tx_arb_if;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       last0;
  logic       last1;
  logic       ack0;
  logic       ack1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic       timeout;

  modport slave (
    input  req0, req1, data0, data1, last0, last1, tx_busy,
    output ack0, ack1, gnt0, gnt1, tx_data, tx_wr, timeout
  );

  modport master (
    output req0, req1, data0, data1, last0, last1, tx_busy,
    input  ack0, ack1, gnt0, gnt1, tx_data, tx_wr, timeout
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, message-locked arbiter for two byte requesters sharing one UART; accept->tx_wr is 1 cycle.
// Backpressure: owner waits while tx_busy is high; an idle owner loses the lock after LOCK_TIMEOUT cycles.
module uart_tx_arb #(
  parameter int LOCK_TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_arb_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_SETTLE,
    S_WAIT_DONE
  } state_t;

  localparam logic [15:0] LP_LIMIT = 16'(LOCK_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_prev;
  logic        r_last;
  logic        r_timeout;
  logic [7:0]  r_data;
  logic [15:0] r_cnt;

  logic        w_accept;
  logic        w_sel;
  logic        w_owner_req;
  logic        w_timeout_hit;
  logic        w_issue;

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_sel         = r_owner;
    w_timeout_hit = 1'b0;
    w_owner_req   = r_owner ? bus.req1 : bus.req0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0 && bus.req1) begin
          w_accept = 1'b1;
          w_sel    = ~r_prev;
        end else if (bus.req0) begin
          w_accept = 1'b1;
          w_sel    = 1'b0;
        end else if (bus.req1) begin
          w_accept = 1'b1;
          w_sel    = 1'b1;
        end
        if (w_accept) w_state_nxt = S_ISSUE;
      end
      S_GRANT: begin
        // An accept in the limit cycle wins over the timeout.
        if (w_owner_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (r_cnt == LP_LIMIT) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_ISSUE:     w_state_nxt = S_SETTLE;
      S_SETTLE:    w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!bus.tx_busy) w_state_nxt = r_last ? S_IDLE : S_GRANT;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_prev    <= 1'b1;
      r_last    <= 1'b0;
      r_data    <= 8'h00;
      r_cnt     <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_timeout_hit;
      if (w_accept) begin
        r_owner <= w_sel;
        r_prev  <= w_sel;
        r_data  <= w_sel ? bus.data1 : bus.data0;
        r_last  <= w_sel ? bus.last1 : bus.last0;
      end
      if (r_state == S_WAIT_DONE && w_state_nxt == S_GRANT) begin
        r_cnt <= 16'd0;
      end else if (r_state == S_GRANT && !w_owner_req) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // r_data only changes on the edge into ISSUE, so tx_data holds between writes.
  assign w_issue     = (r_state == S_ISSUE);
  assign bus.tx_wr   = w_issue;
  assign bus.tx_data = r_data;
  assign bus.ack0    = w_issue & ~r_owner;
  assign bus.ack1    = w_issue &  r_owner;
  assign bus.gnt0    = (r_state != S_IDLE) & ~r_owner;
  assign bus.gnt1    = (r_state != S_IDLE) &  r_owner;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed table, hand-written corner sequences and random traffic
// compared every cycle against a transaction-age reference model.
module tb_uart_tx_arb;
  localparam int T = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if bus();

  uart_tx_arb #(.LOCK_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: owner (-1 = free), age of byte in flight
  // (-1 none, 0 lock held waiting for next byte, 1 write cycle, 2 settle, >=3 waiting on UART).
  int         m_owner = -1;
  int         m_age   = -1;
  int         m_prev  = 1;
  int         m_cnt   = 0;
  logic [7:0] m_txd   = 8'h00;
  logic       m_last  = 1'b0;
  logic       m_to    = 1'b0;

  typedef struct {
    int rst, q0, q1;
    logic [7:0] d0, d1;
    int l0, l1, busy;
    int g0, g1, a0, a1, wr;
    logic [7:0] txd;
    int to;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {18'd0, bus.tx_data, bus.timeout, bus.tx_wr, bus.ack1, bus.ack0, bus.gnt1, bus.gnt0};
  endfunction

  function automatic void accept(input int w);
    m_age  = 1;
    m_txd  = w == 1 ? bus.data1 : bus.data0;
    m_last = w == 1 ? bus.last1 : bus.last0;
  endfunction

  function automatic void model_edge();
    int w;
    logic oreq;
    m_to = 1'b0;
    w = -1;
    if (!reset) begin
      m_owner = -1; m_age = -1; m_prev = 1; m_cnt = 0; m_txd = 8'h00; m_last = 1'b0;
    end else if (m_owner < 0) begin
      if (bus.req0 && bus.req1) w = (m_prev == 1) ? 0 : 1;
      else if (bus.req0) w = 0;
      else if (bus.req1) w = 1;
      if (w >= 0) begin
        m_owner = w;
        m_prev  = w;
        accept(w);
      end
    end else if (m_age == 0) begin
      oreq = (m_owner == 1) ? bus.req1 : bus.req0;
      if (oreq) accept(m_owner);
      else begin
        m_cnt++;
        if (m_cnt == T) begin
          m_owner = -1; m_age = -1; m_to = 1'b1;
        end
      end
    end else if (m_age >= 3) begin
      if (!bus.tx_busy) begin
        if (m_last) begin m_owner = -1; m_age = -1; end
        else begin m_age = 0; m_cnt = 0; end
      end
    end else begin
      m_age++;
    end
  endfunction

  function automatic logic [31:0] model_exp();
    logic wr;
    wr = (m_age == 1);
    return {18'd0, m_txd, m_to, wr, wr && m_owner == 1, wr && m_owner == 0, m_owner == 1, m_owner == 0};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", obs(), model_exp());
  endtask

  task automatic set_in(input logic r, input logic q0, input logic q1, input logic [7:0] d0,
                        input logic [7:0] d1, input logic l0, input logic l1, input logic b);
    reset = r; bus.req0 = q0; bus.req1 = q1; bus.data0 = d0; bus.data1 = d1;
    bus.last0 = l0; bus.last1 = l1; bus.tx_busy = b;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((bus.gnt0 || bus.gnt1) && n < maxc) begin
      step();
      n++;
    end
    chk("idle_bound", 32'(bus.gnt0 | bus.gnt1), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[$];
    logic       own[$];
    int         n;

    set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    //           rst q0 q1 d0     d1     l0 l1 bsy  g0 g1 a0 a1 wr txd    to
    vt[0]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 8'h00, 0};
    vt[1]  = '{0, 1, 0, 8'h61, 8'h00, 1, 0, 0,   0, 0, 0, 0, 0, 8'h00, 0};
    vt[2]  = '{1, 1, 0, 8'h61, 8'h00, 1, 0, 0,   1, 0, 1, 0, 1, 8'h61, 0};
    vt[3]  = '{1, 0, 0, 8'h61, 8'h00, 1, 0, 1,   1, 0, 0, 0, 0, 8'h61, 0};
    vt[4]  = '{1, 0, 0, 8'h61, 8'h00, 1, 0, 1,   1, 0, 0, 0, 0, 8'h61, 0};
    vt[5]  = '{1, 0, 0, 8'h61, 8'h00, 1, 0, 0,   0, 0, 0, 0, 0, 8'h61, 0};
    vt[6]  = '{1, 1, 1, 8'h11, 8'h22, 1, 1, 0,   0, 1, 0, 1, 1, 8'h22, 0};
    vt[7]  = '{1, 1, 0, 8'h11, 8'h22, 1, 1, 0,   0, 1, 0, 0, 0, 8'h22, 0};
    vt[8]  = '{1, 1, 0, 8'h11, 8'h22, 1, 1, 0,   0, 1, 0, 0, 0, 8'h22, 0};
    vt[9]  = '{1, 1, 0, 8'h11, 8'h22, 1, 1, 0,   0, 0, 0, 0, 0, 8'h22, 0};
    vt[10] = '{1, 1, 0, 8'h11, 8'h22, 1, 1, 0,   1, 0, 1, 0, 1, 8'h11, 0};
    vt[11] = '{1, 0, 0, 8'h11, 8'h22, 1, 1, 1,   1, 0, 0, 0, 0, 8'h11, 0};
    vt[12] = '{1, 0, 0, 8'h11, 8'h22, 1, 1, 1,   1, 0, 0, 0, 0, 8'h11, 0};
    vt[13] = '{1, 0, 0, 8'h11, 8'h22, 1, 1, 1,   1, 0, 0, 0, 0, 8'h11, 0};
    vt[14] = '{1, 0, 0, 8'h11, 8'h22, 1, 1, 0,   0, 0, 0, 0, 0, 8'h11, 0};

    for (int i = 0; i < 15; i++) begin
      set_in(vt[i].rst[0], vt[i].q0[0], vt[i].q1[0], vt[i].d0, vt[i].d1,
             vt[i].l0[0], vt[i].l1[0], vt[i].busy[0]);
      step();
      chk($sformatf("vec%0d", i), obs(),
          {18'd0, vt[i].txd, vt[i].to[0], vt[i].wr[0], vt[i].a1[0], vt[i].a0[0],
           vt[i].g1[0], vt[i].g0[0]});
    end

    // Tie alternation after reset
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 8'hA0, 8'hB0, 1'b1, 1'b1, 1'b0);
    step();
    chk("tie0_gnt0", 32'({bus.gnt0, bus.gnt1, bus.ack0}), 32'b101);
    bus.data0 = 8'hA1;
    step(); step(); step();
    chk("tie_release", 32'(bus.gnt0 | bus.gnt1), 32'd0);
    step();
    chk("tie1_gnt1", 32'({bus.gnt0, bus.gnt1, bus.ack1, bus.tx_data}), {21'd0, 3'b011, 8'hB0});
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle(10);

    // Message lock: "ab" from requester 0 while requester 1 waits
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 8'h61, 8'h77, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (seq.size() < 3 && n < 80) begin
      step();
      n++;
      if (bus.tx_wr) begin
        seq.push_back(bus.tx_data);
        own.push_back(bus.gnt1);
      end
      if (bus.ack0 && bus.data0 == 8'h61) begin bus.data0 = 8'h62; bus.last0 = 1'b1; end
      else if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      bus.tx_busy = ($urandom_range(0, 99) < 50);
    end
    chk("lock_count", 32'(seq.size()), 32'd3);
    if (seq.size() == 3) begin
      chk("lock_b0", 32'(seq[0]), 32'h61);
      chk("lock_b1", 32'(seq[1]), 32'h62);
      chk("lock_b2", 32'(seq[2]), 32'h77);
      chk("lock_owner2", 32'(own[2]), 32'd1);
    end
    bus.tx_busy = 1'b0;
    wait_idle(10);

    // Lock timeout, then pending requester 1 granted
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 8'h55, 8'h66, 1'b0, 1'b1, 1'b0);
    step();
    chk("to_ack0", 32'(bus.ack0), 32'd1);
    bus.req0 = 1'b0; bus.req1 = 1'b1;
    step(); step(); step();
    chk("to_grant_held", 32'(bus.gnt0), 32'd1);
    for (int g = 1; g <= T; g++) begin
      step();
      chk($sformatf("to_pulse_g%0d", g), 32'(bus.timeout), 32'(g == T));
      chk($sformatf("to_gnt0_g%0d", g), 32'(bus.gnt0), 32'(g < T));
    end
    step();
    chk("to_then_gnt1", 32'({bus.gnt1, bus.ack1, bus.timeout}), 32'b110);
    bus.req1 = 1'b0;
    wait_idle(10);

    // Owner request in the limit cycle beats the timeout
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 8'h55, 8'h66, 1'b0, 1'b1, 1'b0);
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b1;
    step(); step(); step();
    for (int g = 1; g < T; g++) step();
    bus.req0 = 1'b1; bus.data0 = 8'h56; bus.last0 = 1'b1;
    step();
    chk("race_accept", 32'({bus.ack0, bus.timeout, bus.tx_data}), {22'd0, 2'b10, 8'h56});
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle(10);

    // Reset during WAIT_DONE
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 8'h99, 8'h00, 1'b1, 1'b0, 1'b1);
    step();
    bus.req0 = 1'b0;
    step(); step(); step();
    chk("rst_mid_gnt", 32'(bus.gnt0), 32'd1);
    reset = 1'b0;
    step();
    chk("rst_mid_outputs", obs(), 32'd0);
    reset = 1'b1; bus.tx_busy = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.tx_wr || bus.gnt0 || bus.gnt1) n++;
    end
    chk("rst_no_wr", 32'(n), 32'd0);
    set_in(1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
    step();
    chk("rst_tie_gnt0", 32'({bus.gnt0, bus.gnt1}), 32'b10);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle(10);

    // tx_busy stuck high for 200 cycles
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    chk("busy_first_wr", 32'({bus.tx_wr, bus.tx_data}), {23'd0, 1'b1, 8'hC3});
    bus.data0 = 8'hC4; bus.last0 = 1'b1; bus.tx_busy = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (bus.tx_wr || bus.ack0) n++;
    end
    chk("busy_no_wr", 32'(n), 32'd0);
    bus.tx_busy = 1'b0;
    n = 0;
    do begin step(); n++; end while (!bus.tx_wr && n < 5);
    chk("busy_second_wr", 32'({bus.tx_wr, bus.ack0, bus.tx_data}), {22'd0, 2'b11, 8'hC4});
    bus.req0 = 1'b0;
    wait_idle(10);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!bus.req0 || bus.ack0) begin
        bus.req0  = ($urandom_range(0, 99) < 60);
        bus.data0 = 8'($urandom);
        bus.last0 = ($urandom_range(0, 99) < 40);
      end else if ($urandom_range(0, 99) < 3) bus.req0 = 1'b0;
      if (!bus.req1 || bus.ack1) begin
        bus.req1  = ($urandom_range(0, 99) < 60);
        bus.data1 = 8'($urandom);
        bus.last1 = ($urandom_range(0, 99) < 40);
      end else if ($urandom_range(0, 99) < 3) bus.req1 = 1'b0;
      bus.tx_busy = ($urandom_range(0, 99) < 70);
      reset = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
